sig_freq_ctrl: RTL

- Next-generation front-panel controller for the signal generator.
- Takes four push buttons, edits an NDIGITS-digit BCD frequency, and converts it to binary with a multi-cycle Horner engine.
- Drives the waveform memory with a fractional-accumulator sample tick and an address counter.
- Evenly spaces DEPTH = 2^ADDR_W samples per output period, with clamping and glitch-free waveform-mode switching.

---
 rtl/sig_freq_ctrl_if.sv | 35 +++
 rtl/sig_freq_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sig_freq_ctrl_if.sv
// Front-panel / waveform-memory signal bundle for sig_freq_ctrl.
// master = panel and memory side, slave = the controller.
interface sig_freq_ctrl_if #(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned FREQ_W  = 16,
    parameter int unsigned ADDR_W  = 8
);
    localparam int unsigned CUR_W = $clog2(NDIGITS);

    logic                    btn_cursor;
    logic                    btn_inc;
    logic                    btn_dec;
    logic                    btn_edit;
    logic [1:0]              mode_sel;
    logic [4*NDIGITS-1:0]    digit_out;
    logic [CUR_W-1:0]        cursor;
    logic                    editing;
    logic [FREQ_W-1:0]       freq_bin;
    logic                    freq_valid;
    logic                    samp_tick;
    logic [ADDR_W-1:0]       samp_addr;
    logic [1:0]              wave_mode;

    modport master (
        output btn_cursor, btn_inc, btn_dec, btn_edit, mode_sel,
        input  digit_out, cursor, editing, freq_bin, freq_valid,
               samp_tick, samp_addr, wave_mode
    );

    modport slave (
        input  btn_cursor, btn_inc, btn_dec, btn_edit, mode_sel,
        output digit_out, cursor, editing, freq_bin, freq_valid,
               samp_tick, samp_addr, wave_mode
    );
endinterface

// File: rtl/sig_freq_ctrl.sv
// Signal-generator front panel: debounced BCD editing, Horner BCD-to-binary, sample tick/address.
// Define SIG_PHASE_RESET_EN to restart the waveform at phase 0 on every new frequency.
module sig_freq_ctrl #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned NDIGITS    = 4,
    parameter int unsigned FREQ_W     = 16,
    parameter int unsigned FMAX       = 9999,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input logic           clk,
    input logic           rst_n,
    sig_freq_ctrl_if.slave bus
);
    localparam int unsigned CUR_W  = $clog2(NDIGITS);
    localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned CONV_W = $clog2(10 ** NDIGITS);
    localparam int unsigned STEP_W = FREQ_W + ADDR_W;
    localparam int unsigned PH_W   = $clog2(CLK_HZ);
    localparam int unsigned SUM_W  = ((PH_W > STEP_W) ? PH_W : STEP_W) + 1;

    typedef enum logic [0:0] {StIdle, StConv} conv_st_e;

    // Button order in the vectors: {edit, dec, inc, cursor}
    logic [3:0]            btn_raw, sync1_q, sync2_q, deb_q, press_q;
    logic [3:0][DEB_W-1:0] deb_cnt_q;

    logic [NDIGITS-1:0][3:0] digits_q;
    logic [CUR_W-1:0]        cursor_q;
    logic                    editing_q;
    logic                    conv_start_q;
    logic [3:0]              sel_digit, inc_digit, dec_digit;
    logic                    dig_wr;

    conv_st_e          st_q;
    logic [CUR_W-1:0]  idx_q;
    logic [CONV_W-1:0] conv_q, conv_nxt, conv_clamped;
    logic [FREQ_W-1:0] freq_bin_q;
    logic              freq_valid_q;
    logic              load;

    logic [PH_W-1:0]   ph_q;
    logic [STEP_W-1:0] step;
    logic [SUM_W-1:0]  sum;
    logic              wrap_hit;
    logic              samp_tick_q;
    logic [ADDR_W-1:0] samp_addr_q;
    logic [1:0]        wave_mode_q;

    assign btn_raw = {bus.btn_edit, bus.btn_dec, bus.btn_inc, bus.btn_cursor};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            press_q   <= '0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_cnt_q[i] <= '0;
                    deb_q[i]     <= sync2_q[i];
                    press_q[i]   <= sync2_q[i];
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    always_comb begin
        sel_digit = digits_q[cursor_q];
        inc_digit = (sel_digit == 4'd9) ? 4'd0 : sel_digit + 4'd1;
        dec_digit = (sel_digit == 4'd0) ? 4'd9 : sel_digit - 4'd1;
        // Simultaneous inc and dec cancel out.
        dig_wr    = editing_q & (press_q[1] ^ press_q[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q     <= '0;
            cursor_q     <= '0;
            editing_q    <= 1'b1;
            conv_start_q <= 1'b1;
        end else begin
            conv_start_q <= dig_wr;
            if (press_q[3]) editing_q <= ~editing_q;
            if (editing_q && press_q[0]) begin
                cursor_q <= (cursor_q == CUR_W'(NDIGITS - 1)) ? '0 : cursor_q + CUR_W'(1);
            end
            if (dig_wr) digits_q[cursor_q] <= press_q[1] ? inc_digit : dec_digit;
        end
    end

    always_comb begin
        conv_nxt     = conv_q * CONV_W'(10) + CONV_W'(digits_q[idx_q]);
        conv_clamped = (conv_nxt > CONV_W'(FMAX)) ? CONV_W'(FMAX) : conv_nxt;
        // A digit write on the final step would be stale; the restart next cycle handles it.
        load         = (st_q == StConv) && !conv_start_q && !dig_wr && (idx_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= StIdle;
            idx_q        <= '0;
            conv_q       <= '0;
            freq_bin_q   <= '0;
            freq_valid_q <= 1'b0;
        end else if (conv_start_q) begin
            st_q         <= StConv;
            idx_q        <= CUR_W'(NDIGITS - 1);
            conv_q       <= '0;
            freq_valid_q <= 1'b0;
        end else if (st_q == StConv) begin
            conv_q <= conv_nxt;
            if (idx_q != '0) begin
                idx_q <= idx_q - CUR_W'(1);
            end else if (!dig_wr) begin
                st_q         <= StIdle;
                freq_bin_q   <= FREQ_W'(conv_clamped);
                freq_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        step     = STEP_W'(freq_bin_q) << ADDR_W;
        sum      = SUM_W'(ph_q) + SUM_W'(step);
        wrap_hit = (sum >= SUM_W'(CLK_HZ));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q        <= '0;
            samp_tick_q <= 1'b0;
            samp_addr_q <= '0;
            wave_mode_q <= 2'd0;
        end else begin
            samp_tick_q <= wrap_hit;
            if (wrap_hit) begin
                ph_q        <= PH_W'(sum - SUM_W'(CLK_HZ));
                samp_addr_q <= samp_addr_q + ADDR_W'(1);
            end else begin
                ph_q <= PH_W'(sum);
            end
            // Mode changes only at a period boundary so the output never glitches.
            if ((wrap_hit && (samp_addr_q == '1)) || (freq_bin_q == '0)) begin
                wave_mode_q <= bus.mode_sel;
            end
`ifdef SIG_PHASE_RESET_EN
            if (load) begin
                ph_q        <= '0;
                samp_addr_q <= '0;
            end
`else
            if (load) begin
                samp_addr_q <= samp_addr_q + ADDR_W'(wrap_hit);
            end
`endif
        end
    end

    assign bus.digit_out  = digits_q;
    assign bus.cursor     = cursor_q;
    assign bus.editing    = editing_q;
    assign bus.freq_bin   = freq_bin_q;
    assign bus.freq_valid = freq_valid_q;
    assign bus.samp_tick  = samp_tick_q;
    assign bus.samp_addr  = samp_addr_q;
    assign bus.wave_mode  = wave_mode_q;
endmodule
